// File: rtl/click_classifier_if.sv
// click_classifier_if: groups the press/tick inputs and the classification
// outputs of click_classifier.
//   CEI    prescaler tick, one CLK wide
//   PE     debounced press pulse, one CLK wide
//   SINGLE one-cycle pulse, single click classified
//   DOUBLE one-cycle pulse, double click classified
//   BUSY   first press waiting for a possible second press
//   SCNT   single click count, 4-bit wrap
//   DCNT   double click count, 4-bit wrap
// Modports: master drives CEI/PE and observes results; slave is the classifier.
interface click_classifier_if;
  logic       CEI;
  logic       PE;
  logic       SINGLE;
  logic       DOUBLE;
  logic       BUSY;
  logic [3:0] SCNT;
  logic [3:0] DCNT;

  modport master (
    output CEI, PE,
    input  SINGLE, DOUBLE, BUSY, SCNT, DCNT
  );

  modport slave (
    input  CEI, PE,
    output SINGLE, DOUBLE, BUSY, SCNT, DCNT
  );
endinterface

// File: rtl/click_classifier.sv
// click_classifier: classifies debounced presses as single or double clicks.
// A second press within WINDOW prescaler ticks of the first gives a double
// click; otherwise the window expiry gives a single click.
// Ports:
//   CLK  system clock, rising edge
//   CLR  asynchronous active-low reset
//   bus  click_classifier_if.slave (CEI, PE in; SINGLE, DOUBLE, BUSY,
//        SCNT, DCNT out, all registered)
// Parameters:
//   WINDOW  ticks in the double-click window, 1..2^CW-1
//   CW      tick counter width
module click_classifier #(
  parameter int unsigned WINDOW = 50,
  parameter int unsigned CW     = 8
) (
  input  logic               CLK,
  input  logic               CLR,
  click_classifier_if.slave  bus
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          single_q;
  logic          double_q;
  logic          busy_q;
  logic [3:0]    scnt_q;
  logic [3:0]    dcnt_q;

  // busy_q is kept as its own register mirroring state==ST_WAIT so BUSY
  // drops on the same edge that raises SINGLE or DOUBLE.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
      scnt_q   <= '0;
      dcnt_q   <= '0;
    end else begin
      single_q <= 1'b0;
      double_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A tick coinciding with the first press is not counted.
          if (bus.PE) begin
            state  <= ST_WAIT;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          // Press takes priority over a terminal tick in the same cycle.
          if (bus.PE) begin
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
            double_q <= 1'b1;
            dcnt_q   <= dcnt_q + 4'd1;
          end else if (bus.CEI) begin
            if (cnt == LAST) begin
              state    <= ST_IDLE;
              busy_q   <= 1'b0;
              single_q <= 1'b1;
              scnt_q   <= scnt_q + 4'd1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SINGLE = single_q;
  assign bus.DOUBLE = double_q;
  assign bus.BUSY   = busy_q;
  assign bus.SCNT   = scnt_q;
  assign bus.DCNT   = dcnt_q;

endmodule
